// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if
// Bundles the three buses seen by the memory stage:
//   EX/MEM side : wb_en, mem_read_en, mem_write_en, alu_res, val_rm, dest (in), freeze (out)
//   SRAM side   : sram_addr, sram_wdata, sram_we_n (out), sram_rdata (in)
//   MEM/WB side : wb_en_out, mem_read_en_out, alu_res_out, mem_data_out, dest_out (out)
// slave  = memory stage view, master = surrounding pipeline / SRAM view.
interface mem_stage_ctrl_if;
    logic        wb_en;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] alu_res;
    logic [31:0] val_rm;
    logic [3:0]  dest;
    logic        freeze;

    logic [17:0] sram_addr;
    logic [15:0] sram_wdata;
    logic        sram_we_n;
    logic [15:0] sram_rdata;

    logic        wb_en_out;
    logic        mem_read_en_out;
    logic [31:0] alu_res_out;
    logic [31:0] mem_data_out;
    logic [3:0]  dest_out;

    modport slave (
        input  wb_en, mem_read_en, mem_write_en, alu_res, val_rm, dest, sram_rdata,
        output freeze, sram_addr, sram_wdata, sram_we_n,
               wb_en_out, mem_read_en_out, alu_res_out, mem_data_out, dest_out
    );

    modport master (
        output wb_en, mem_read_en, mem_write_en, alu_res, val_rm, dest, sram_rdata,
        input  freeze, sram_addr, sram_wdata, sram_we_n,
               wb_en_out, mem_read_en_out, alu_res_out, mem_data_out, dest_out
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
// Memory stage: performs the data-memory access for the instruction held in
// EX/MEM over a 16-bit SRAM (each word = low half-word then high half-word,
// each phase held WAIT_CYCLES cycles), stalls upstream with freeze while the
// access is in flight, and holds the MEM/WB pipeline register.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - mem_stage_ctrl_if.slave (EX/MEM inputs, SRAM port, MEM/WB outputs)
module mem_stage_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    mem_stage_ctrl_if.slave bus
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic          r_is_rd;
    logic [16:0]   r_word;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic [17:0]   r_sram_addr;
    logic [15:0]   r_sram_wdata;

    logic          w_req;
    logic          w_last;
    logic          w_freeze;
    logic [16:0]   w_word;

    assign w_req  = bus.mem_read_en | bus.mem_write_en;
    // Offset from BASE_ADDR wraps modulo 2^32; keep word bits [18:2].
    assign w_word = 17'((bus.alu_res - BASE_ADDR) >> 2);
    assign w_last = (r_cnt == CW'(WAIT_CYCLES - 1));

    always_comb begin
        w_next   = r_state;
        w_freeze = 1'b0;
        case (r_state)
            IDLE: if (w_req) begin
                w_freeze = 1'b1;
                w_next   = LO;
            end
            LO: begin
                w_freeze = 1'b1;
                if (w_last) w_next = HI;
            end
            HI: begin
                w_freeze = 1'b1;
                if (w_last) w_next = DONE;
            end
            // The request is still presented here (EX/MEM only advances on
            // this edge), so DONE must not look at it.
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Reset is gated in so freeze drops immediately on an asynchronous reset.
    assign bus.freeze     = w_freeze & rst;
    assign bus.sram_we_n  = ~(((r_state == LO) || (r_state == HI)) & ~r_is_rd);
    assign bus.sram_addr  = r_sram_addr;
    assign bus.sram_wdata = r_sram_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state             <= IDLE;
            r_cnt               <= '0;
            r_is_rd             <= 1'b0;
            r_word              <= '0;
            r_wdata             <= '0;
            r_rdata             <= '0;
            r_sram_addr         <= '0;
            r_sram_wdata        <= '0;
            bus.wb_en_out       <= 1'b0;
            bus.mem_read_en_out <= 1'b0;
            bus.alu_res_out     <= '0;
            bus.mem_data_out    <= '0;
            bus.dest_out        <= '0;
        end else begin
            r_state <= w_next;

            case (r_state)
                IDLE: if (w_req) begin
                    // Read wins when both strobes are set.
                    r_is_rd      <= bus.mem_read_en;
                    r_word       <= w_word;
                    r_wdata      <= bus.val_rm;
                    r_cnt        <= '0;
                    r_sram_addr  <= {w_word, 1'b0};
                    r_sram_wdata <= bus.val_rm[15:0];
                end
                LO: begin
                    if (w_last) begin
                        r_cnt         <= '0;
                        r_rdata[15:0] <= bus.sram_rdata;
                        r_sram_addr   <= {r_word, 1'b1};
                        r_sram_wdata  <= r_wdata[31:16];
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                HI: begin
                    if (w_last) begin
                        r_cnt          <= '0;
                        r_rdata[31:16] <= bus.sram_rdata;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase

            // MEM/WB: bubble while frozen so write-back fires once per op.
            if (w_freeze) begin
                bus.wb_en_out       <= 1'b0;
                bus.mem_read_en_out <= 1'b0;
            end else begin
                bus.wb_en_out       <= bus.wb_en;
                bus.mem_read_en_out <= bus.mem_read_en;
                bus.alu_res_out     <= bus.alu_res;
                bus.dest_out        <= bus.dest;
                if ((r_state == DONE) && r_is_rd)
                    bus.mem_data_out <= r_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_err = 0;
    int   n_chk = 0;

    mem_stage_ctrl_if bus ();

    mem_stage_ctrl #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Small SRAM read model: fixed contents at half-word 4 and 5.
    assign bus.sram_rdata = (bus.sram_addr == 18'h00004) ? 16'h1234 :
                            (bus.sram_addr == 18'h00005) ? 16'hABCD : 16'h0000;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic wb, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] v, input logic [3:0] d);
        bus.wb_en        = wb;
        bus.mem_read_en  = rd;
        bus.mem_write_en = wr;
        bus.alu_res      = a;
        bus.val_rm       = v;
        bus.dest         = d;
    endtask

    initial begin
        set_in(0, 0, 0, 32'h0, 32'h0, 4'h0);
        rst = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_freeze",  {31'b0, bus.freeze},          32'h0);
        chk("rst_we_n",    {31'b0, bus.sram_we_n},       32'h1);
        chk("rst_addr",    {14'b0, bus.sram_addr},       32'h0);
        chk("rst_wdata",   {16'b0, bus.sram_wdata},      32'h0);
        chk("rst_wb",      {31'b0, bus.wb_en_out},       32'h0);
        chk("rst_memdata", bus.mem_data_out,             32'h0);
        rst = 1'b1;
        tick();

        // Non-mem pass-through
        set_in(1, 0, 0, 32'h55, 32'h0, 4'd3);
        #1 chk("pt_freeze", {31'b0, bus.freeze}, 32'h0);
        tick();
        chk("pt_wb",   {31'b0, bus.wb_en_out},       32'h1);
        chk("pt_alu",  bus.alu_res_out,              32'h55);
        chk("pt_dest", {28'b0, bus.dest_out},        32'h3);
        chk("pt_rd",   {31'b0, bus.mem_read_en_out}, 32'h0);

        // Store 0xDEADBEEF @ 0x408 -> half-words 4 (BEEF), 5 (DEAD)
        set_in(0, 0, 1, 32'h408, 32'hDEAD_BEEF, 4'd0);
        #1 chk("st_freeze0", {31'b0, bus.freeze}, 32'h1);
        chk("st_we0", {31'b0, bus.sram_we_n}, 32'h1);
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("st_freeze", {31'b0, bus.freeze},    32'h1);
            chk("st_we",     {31'b0, bus.sram_we_n}, 32'h0);
            chk("st_addr",   {14'b0, bus.sram_addr},  (c <= 2) ? 32'h4 : 32'h5);
            chk("st_wdata",  {16'b0, bus.sram_wdata}, (c <= 2) ? 32'hBEEF : 32'hDEAD);
            chk("st_wb",     {31'b0, bus.wb_en_out}, 32'h0);
        end
        tick();
        chk("st_done_freeze", {31'b0, bus.freeze},    32'h0);
        chk("st_done_we",     {31'b0, bus.sram_we_n}, 32'h1);
        tick();
        chk("st_wb_out",   {31'b0, bus.wb_en_out},       32'h0);
        chk("st_rd_out",   {31'b0, bus.mem_read_en_out}, 32'h0);
        chk("st_memdata",  bus.mem_data_out,             32'h0);

        // Load @ 0x408, wb_en=1, dest=7
        set_in(1, 1, 0, 32'h408, 32'h0, 4'd7);
        #1 chk("ld_freeze0", {31'b0, bus.freeze}, 32'h1);
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk("ld_freeze", {31'b0, bus.freeze},    (c <= 4) ? 32'h1 : 32'h0);
            chk("ld_we",     {31'b0, bus.sram_we_n}, 32'h1);
            chk("ld_wb",     {31'b0, bus.wb_en_out}, 32'h0);
        end
        tick();
        chk("ld_data", bus.mem_data_out,             32'hABCD_1234);
        chk("ld_rd",   {31'b0, bus.mem_read_en_out}, 32'h1);
        chk("ld_wb1",  {31'b0, bus.wb_en_out},       32'h1);
        chk("ld_dest", {28'b0, bus.dest_out},        32'h7);
        chk("ld_alu",  bus.alu_res_out,              32'h408);

        // rd+wr together (read wins), then store back-to-back with address wrap
        set_in(1, 1, 1, 32'h408, 32'h1111_2222, 4'd5);
        #1 chk("rw_freeze0", {31'b0, bus.freeze}, 32'h1);
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk("rw_freeze", {31'b0, bus.freeze},    (c <= 4) ? 32'h1 : 32'h0);
            chk("rw_we",     {31'b0, bus.sram_we_n}, 32'h1);
        end
        tick();
        chk("rw_data", bus.mem_data_out,             32'hABCD_1234);
        chk("rw_rd",   {31'b0, bus.mem_read_en_out}, 32'h1);
        chk("rw_wb",   {31'b0, bus.wb_en_out},       32'h1);
        chk("rw_idle_we", {31'b0, bus.sram_we_n},    32'h1);
        // Next op presented the cycle after DONE, detected in IDLE.
        set_in(0, 0, 1, 32'h0, 32'hCAFE_F00D, 4'd0);
        #1 chk("wr_freeze0", {31'b0, bus.freeze}, 32'h1);
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("wr_we",    {31'b0, bus.sram_we_n},  32'h0);
            chk("wr_addr",  {14'b0, bus.sram_addr},  (c <= 2) ? 32'h3FE00 : 32'h3FE01);
            chk("wr_wdata", {16'b0, bus.sram_wdata}, (c <= 2) ? 32'hF00D : 32'hCAFE);
        end
        tick();
        chk("wr_done_freeze", {31'b0, bus.freeze}, 32'h0);
        tick();
        chk("wr_wb_out", {31'b0, bus.wb_en_out}, 32'h0);
        chk("wr_memdata_hold", bus.mem_data_out, 32'hABCD_1234);

        // Reset during HI phase of a write
        set_in(1, 0, 1, 32'h40C, 32'h5555_AAAA, 4'd9);
        tick(); tick(); tick();
        chk("mr_hi_we", {31'b0, bus.sram_we_n}, 32'h0);
        #2 rst = 1'b0;
        #1;
        chk("mr_we",      {31'b0, bus.sram_we_n},       32'h1);
        chk("mr_freeze",  {31'b0, bus.freeze},          32'h0);
        chk("mr_wb",      {31'b0, bus.wb_en_out},       32'h0);
        chk("mr_rd",      {31'b0, bus.mem_read_en_out}, 32'h0);
        chk("mr_alu",     bus.alu_res_out,              32'h0);
        chk("mr_dest",    {28'b0, bus.dest_out},        32'h0);
        chk("mr_memdata", bus.mem_data_out,             32'h0);
        chk("mr_addr",    {14'b0, bus.sram_addr},       32'h0);
        set_in(0, 0, 0, 32'h0, 32'h0, 4'd0);
        tick();
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("post_rst_we",     {31'b0, bus.sram_we_n}, 32'h1);
            chk("post_rst_freeze", {31'b0, bus.freeze},    32'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
